// File: rtl/temperature_sample_accumulator.sv
// Window accumulator: sums 64 unsigned samples into a 32-bit total
// for the divide-by-64 stage downstream (average = sum_o[31:6]).
module temperature_sample_accumulator #(
  parameter int SAMPLE_W  = 16,
  parameter int N_SAMPLES = 64,
  parameter int COUNT_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [31:0]         sum_out,
  output logic                sum_valid,
  input  logic                sum_ready,
  output logic [COUNT_W-1:0]  sample_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(N_SAMPLES - 1);

  state_t               state_q, state_d;
  logic [31:0]          acc_q, acc_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [31:0]          sum_q, sum_d;
  logic                 sum_valid_q, sum_valid_d;
  logic [31:0]          sample_ext;
  logic                 accept;

  assign sample_ext   = {{(32-SAMPLE_W){1'b0}}, sample_in};
  assign sample_ready = (state_q != HOLD);
  assign accept       = sample_valid & sample_ready;

  assign sum_out      = sum_q;
  assign sum_valid    = sum_valid_q;
  assign sample_count = count_q;

  // Next-state: accumulate, close the window, hand off, or abort on clear
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;

    if (accept) begin
      if (count_q == LAST) begin
        sum_d       = acc_q + sample_ext;
        sum_valid_d = 1'b1;
        acc_d       = '0;
        count_d     = '0;
        state_d     = HOLD;
      end else begin
        acc_d   = acc_q + sample_ext;
        count_d = count_q + 1'b1;
        state_d = ACCUM;
      end
    end

    if (state_q == HOLD && sum_valid_q && sum_ready) begin
      sum_valid_d = 1'b0;
      state_d     = IDLE;
    end

    // Abort drops the partial window and any pending sum; sum value kept
    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      count_d     = '0;
      sum_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

endmodule

// File: tb/tb_temperature_sample_accumulator.sv
// Scoreboard bench for temperature_sample_accumulator:
// expected sums queued at stimulus, popped by a monitor on sum_valid rise.
module tb_temperature_sample_accumulator;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] sum_out;
  logic        sum_valid;
  logic        sum_ready;
  logic [5:0]  sample_count;

  int n_checks;
  int n_pass;
  logic [31:0] exp_q[$];
  logic        sv_prev;

  temperature_sample_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sum_out      (sum_out),
    .sum_valid    (sum_valid),
    .sum_ready    (sum_ready),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) step();
    end
    sample_in    = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  // Monitor: each new presentation of sum_valid consumes one expectation
  always @(negedge clk) begin
    if (rst) begin
      sv_prev <= 1'b0;
    end else begin
      if (sum_valid && !sv_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sum", sum_out, 32'hFFFF_FFFF);
        end else begin
          check("sum_out", sum_out, exp_q.pop_front());
        end
      end
      sv_prev <= sum_valid;
    end
  end

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    sv_prev      = 1'b0;
    rst          = 1'b1;
    clear        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    sum_ready    = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_sum_valid", 32'(sum_valid), 0);
    check("reset_sum_out", sum_out, 0);
    check("reset_count", 32'(sample_count), 0);
    check("reset_ready", 32'(sample_ready), 1);

    // 1: 64 x 100 back-to-back
    exp_q.push_back(32'd6400);
    for (int i = 0; i < 64; i++) send(16'd100, 1'b0);
    check("t1_latency_valid", 32'(sum_valid), 1);
    check("t1_avg", 32'(sum_out[31:6]), 100);
    step();
    check("t1_valid_one_cycle", 32'(sum_valid), 0);
    check("t1_sum_kept", sum_out, 6400);
    check("t1_ready_back", 32'(sample_ready), 1);

    // 2: ramp 0..63 with gaps, count tracks
    exp_q.push_back(32'd2016);
    for (int i = 0; i < 64; i++) begin
      check("t2_count", 32'(sample_count), i);
      send(16'(i), 1'b1);
    end
    check("t2_valid", 32'(sum_valid), 1);
    step();

    // 3: full-scale samples, no wrap
    exp_q.push_back(32'd4194240);
    for (int i = 0; i < 64; i++) send(16'hFFFF, 1'b0);
    check("t3_sum", sum_out, 32'd4194240);
    step();

    // 4: downstream stalls for 5 cycles while upstream pushes
    sum_ready = 1'b0;
    exp_q.push_back(32'd6400);
    for (int i = 0; i < 64; i++) send(16'd100, 1'b0);
    sample_in    = 16'd55;
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(sum_valid), 1);
      check("t4_hold_sum", sum_out, 6400);
      check("t4_hold_ready", 32'(sample_ready), 0);
      check("t4_hold_count", 32'(sample_count), 0);
      step();
    end
    sum_ready = 1'b1;
    step();
    sample_valid = 1'b0;
    check("t4_released", 32'(sum_valid), 0);
    check("t4_ready_after", 32'(sample_ready), 1);
    check("t4_count_fresh", 32'(sample_count), 0);
    exp_q.push_back(32'd128);
    for (int i = 0; i < 64; i++) send(16'd2, 1'b0);
    step();

    // 5a: reset mid-window
    for (int i = 0; i < 10; i++) send(16'd7, 1'b0);
    check("t5_count10", 32'(sample_count), 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_count", 32'(sample_count), 0);
    exp_q.push_back(32'd64);
    for (int i = 0; i < 64; i++) send(16'd1, 1'b0);
    step();

    // 5b: clear mid-window with a coincident sample
    for (int i = 0; i < 10; i++) send(16'd7, 1'b0);
    clear        = 1'b1;
    sample_in    = 16'd7;
    sample_valid = 1'b1;
    step();
    clear        = 1'b0;
    sample_valid = 1'b0;
    check("t5_clear_count", 32'(sample_count), 0);
    exp_q.push_back(32'd64);
    for (int i = 0; i < 64; i++) send(16'd1, 1'b0);
    step();

    // 6: reset during HOLD
    sum_ready = 1'b0;
    exp_q.push_back(32'd192);
    for (int i = 0; i < 64; i++) send(16'd3, 1'b0);
    step();
    check("t6_holding", 32'(sum_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", 32'(sum_valid), 0);
    check("t6_ready", 32'(sample_ready), 1);
    check("t6_sum", sum_out, 0);
    sum_ready = 1'b1;

    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
